// File: rtl/risc_pkg.sv
// Shared widths and FSM state encoding for the two-port memory arbiter.
package risc_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned MAX_BURST  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port
// that was not granted last.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       valid
);

    // Tie-break toward the port that did not win most recently
    always_comb begin
        valid  = |req;
        winner = 1'b0;
        if (req == 2'b11) begin
            winner = ~last;
        end else begin
            winner = req[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port single-memory arbiter: CPU on port 0, loader/DMA on port 1,
// round-robin on ties, optional locked bursts capped at MAX_BURST beats.
module mem_arbiter #(
    parameter int unsigned DATA_WIDTH = risc_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = risc_pkg::ADDR_WIDTH,
    parameter int unsigned MAX_BURST  = risc_pkg::MAX_BURST
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic                  lock0,
    input  logic                  lock1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  owner,
    output logic                  busy
);

    import risc_pkg::*;

    localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);

    arb_state_t            state;
    arb_state_t            state_n;
    logic                  win;
    logic                  win_n;
    logic                  we_q;
    logic                  we_n;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] wdata_n;
    logic [BEAT_W-1:0]     beat_cnt;
    logic [BEAT_W-1:0]     beat_n;
    logic                  last_grant;
    logic                  last_n;

    logic                  pick_winner;
    logic                  pick_valid;
    logic                  src_port;
    logic                  src_we;
    logic [ADDR_WIDTH-1:0] src_addr;
    logic [DATA_WIDTH-1:0] src_wdata;
    logic                  cont;
    logic                  in_issue;
    logic                  in_resp;

    rr_pick2 u_pick (
        .req    ({req1, req0}),
        .last   (last_grant),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    // Port whose inputs get latched: the arbitration winner from IDLE,
    // otherwise the current owner continuing a locked burst
    assign src_port  = (state == IDLE) ? pick_winner : win;
    assign src_we    = src_port ? we1    : we0;
    assign src_addr  = src_port ? addr1  : addr0;
    assign src_wdata = src_port ? wdata1 : wdata0;

    // Owner still asking for a locked beat and has budget left
    assign cont = (win ? (req1 && lock1) : (req0 && lock0))
                  && (beat_cnt < BEAT_W'(MAX_BURST));

    // Next-state, latch and beat-counter logic
    always_comb begin
        state_n = state;
        win_n   = win;
        we_n    = we_q;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        beat_n  = beat_cnt;
        last_n  = last_grant;

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_n = ISSUE;
                    win_n   = pick_winner;
                    we_n    = src_we;
                    addr_n  = src_addr;
                    wdata_n = src_wdata;
                    beat_n  = BEAT_W'(1);
                    last_n  = pick_winner;
                end
            end
            ISSUE, RESP: begin
                if ((state == ISSUE) && !we_q) begin
                    state_n = RESP;
                end else if (cont) begin
                    state_n = ISSUE;
                    we_n    = src_we;
                    addr_n  = src_addr;
                    wdata_n = src_wdata;
                    beat_n  = beat_cnt + BEAT_W'(1);
                    last_n  = win;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and latched-command registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            win        <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            beat_cnt   <= '0;
            last_grant <= 1'b1;
        end else begin
            state      <= state_n;
            win        <= win_n;
            we_q       <= we_n;
            addr_q     <= addr_n;
            wdata_q    <= wdata_n;
            beat_cnt   <= beat_n;
            last_grant <= last_n;
        end
    end

    // Strobes decode from registered state; a low rst kills them at once so
    // an access caught by reset issues nothing further
    assign in_issue = rst && (state == ISSUE);
    assign in_resp  = rst && (state == RESP);

    // Outputs: memory command in ISSUE, read return in RESP
    always_comb begin
        gnt0      = in_issue && !win;
        gnt1      = in_issue && win;
        mem_rd    = in_issue && !we_q;
        mem_wr    = in_issue && we_q;
        mem_addr  = in_issue ? addr_q  : '0;
        mem_wdata = in_issue ? wdata_q : '0;
        rvalid0   = in_resp && !win;
        rvalid1   = in_resp && win;
        rdata     = in_resp ? mem_rdata : '0;
        busy      = rst && (state != IDLE);
        owner     = rst && win;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table plus burst and reset sequences,
// with a small synchronous memory model behind the arbiter.
module tb_mem_arbiter;

    typedef struct packed {
        logic       rst;
        logic       req0;
        logic       req1;
        logic       we0;
        logic       we1;
        logic       lock1;
        logic [4:0] addr0;
        logic [4:0] addr1;
        logic [7:0] wdata1;
    } ins_t;

    typedef struct packed {
        logic       g0;
        logic       g1;
        logic       rv0;
        logic       rv1;
        logic       rd;
        logic       wr;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic       busy;
        logic       own;
    } outs_t;

    typedef struct packed {
        ins_t  i;
        outs_t o;
    } vec_t;

    localparam int NV = 23;
    localparam int NB = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, we0, we1, lock0, lock1;
    logic [4:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata;
    logic       mem_rd, mem_wr;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic       owner, busy;
    logic       preload;

    logic [7:0] mem [32];

    int total = 0;
    int bad   = 0;

    vec_t  vecs [NV];
    outs_t bexp [NB];

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .lock0     (lock0),
        .lock1     (lock1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .owner     (owner),
        .busy      (busy)
    );

    // Memory: read data one cycle after mem_rd, writes land at the edge
    always @(posedge clk) begin
        if (preload) begin
            for (int a = 0; a < 32; a++) begin
                mem[a] <= (a == 10) ? 8'h3C : 8'hA0 + 8'(a);
            end
        end else begin
            if (mem_wr) mem[mem_addr] <= mem_wdata;
            if (mem_rd) mem_rdata <= mem[mem_addr];
        end
    end

    function automatic ins_t mk_i(input logic r, input logic q0, input logic q1,
                                  input logic w0, input logic w1, input logic l1,
                                  input logic [4:0] a0, input logic [4:0] a1,
                                  input logic [7:0] wd1);
        return '{r, q0, q1, w0, w1, l1, a0, a1, wd1};
    endfunction

    function automatic outs_t mk_o(input logic g0, input logic g1, input logic v0,
                                   input logic v1, input logic rd, input logic wr,
                                   input logic [4:0] a, input logic [7:0] wd,
                                   input logic [7:0] rdd, input logic b, input logic ow);
        return '{g0, g1, v0, v1, rd, wr, a, wd, rdd, b, ow};
    endfunction

    function automatic outs_t quiet(input logic ow);
        return mk_o(0, 0, 0, 0, 0, 0, 5'h00, 8'h00, 8'h00, 0, ow);
    endfunction

    task automatic apply(input ins_t v);
        rst    = v.rst;
        req0   = v.req0;
        req1   = v.req1;
        we0    = v.we0;
        we1    = v.we1;
        lock1  = v.lock1;
        addr0  = v.addr0;
        addr1  = v.addr1;
        wdata1 = v.wdata1;
    endtask

    task automatic check(input string nm, input outs_t exp);
        outs_t act;
        act = '{gnt0, gnt1, rvalid0, rvalid1, mem_rd, mem_wr, mem_addr,
                mem_wdata, rdata, busy, owner};
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got g0=%b g1=%b rv0=%b rv1=%b rd=%b wr=%b addr=%h wd=%h rdata=%h busy=%b own=%b | want g0=%b g1=%b rv0=%b rv1=%b rd=%b wr=%b addr=%h wd=%h rdata=%h busy=%b own=%b",
                     nm, act.g0, act.g1, act.rv0, act.rv1, act.rd, act.wr, act.addr,
                     act.wdata, act.rdata, act.busy, act.own,
                     exp.g0, exp.g1, exp.rv0, exp.rv1, exp.rd, exp.wr, exp.addr,
                     exp.wdata, exp.rdata, exp.busy, exp.own);
        end
    endtask

    task automatic check_mem(input string nm, input int a, input logic [7:0] exp);
        total++;
        if (mem[a] !== exp) begin
            bad++;
            $display("FAIL %s: mem[%0d] got=%h want=%h", nm, a, mem[a], exp);
        end
    endtask

    initial begin
        int beats;

        // Reset hold, single read, tie after reset, withdrawal, single write
        vecs[0]  = '{mk_i(0,1,1,0,0,0,5'h00,5'h00,8'h00), quiet(0)};
        vecs[1]  = '{mk_i(0,1,1,0,0,0,5'h00,5'h00,8'h00), quiet(0)};
        vecs[2]  = '{mk_i(0,1,1,0,0,0,5'h00,5'h00,8'h00), quiet(0)};
        vecs[3]  = '{mk_i(1,1,0,0,0,0,5'h0A,5'h00,8'h00), quiet(0)};
        vecs[4]  = '{mk_i(1,0,0,0,0,0,5'h0A,5'h00,8'h00), mk_o(1,0,0,0,1,0,5'h0A,8'h00,8'h00,1,0)};
        vecs[5]  = '{mk_i(1,0,0,0,0,0,5'h00,5'h00,8'h00), mk_o(0,0,1,0,0,0,5'h00,8'h00,8'h3C,1,0)};
        vecs[6]  = '{mk_i(1,0,0,0,0,0,5'h00,5'h00,8'h00), quiet(0)};
        vecs[7]  = '{mk_i(0,0,0,0,0,0,5'h00,5'h00,8'h00), quiet(0)};
        vecs[8]  = '{mk_i(1,1,1,0,0,0,5'h03,5'h07,8'h00), quiet(0)};
        vecs[9]  = '{mk_i(1,0,1,0,0,0,5'h03,5'h07,8'h00), mk_o(1,0,0,0,1,0,5'h03,8'h00,8'h00,1,0)};
        vecs[10] = '{mk_i(1,0,1,0,0,0,5'h03,5'h07,8'h00), mk_o(0,0,1,0,0,0,5'h00,8'h00,8'hA3,1,0)};
        vecs[11] = '{mk_i(1,0,1,0,0,0,5'h03,5'h07,8'h00), quiet(0)};
        vecs[12] = '{mk_i(1,0,0,0,0,0,5'h00,5'h07,8'h00), mk_o(0,1,0,0,1,0,5'h07,8'h00,8'h00,1,1)};
        vecs[13] = '{mk_i(1,0,0,0,0,0,5'h00,5'h00,8'h00), mk_o(0,0,0,1,0,0,5'h00,8'h00,8'hA7,1,1)};
        vecs[14] = '{mk_i(1,0,0,0,0,0,5'h00,5'h00,8'h00), quiet(1)};
        vecs[15] = '{mk_i(1,1,0,0,0,0,5'h02,5'h00,8'h00), quiet(1)};
        vecs[16] = '{mk_i(1,0,1,0,0,0,5'h02,5'h09,8'h00), mk_o(1,0,0,0,1,0,5'h02,8'h00,8'h00,1,0)};
        vecs[17] = '{mk_i(1,0,0,0,0,0,5'h00,5'h00,8'h00), mk_o(0,0,1,0,0,0,5'h00,8'h00,8'hA2,1,0)};
        vecs[18] = '{mk_i(1,0,0,0,0,0,5'h00,5'h00,8'h00), quiet(0)};
        vecs[19] = '{mk_i(1,0,0,0,0,0,5'h00,5'h00,8'h00), quiet(0)};
        vecs[20] = '{mk_i(1,0,1,0,1,0,5'h00,5'h1F,8'h5A), quiet(0)};
        vecs[21] = '{mk_i(1,0,0,0,1,0,5'h00,5'h1F,8'h5A), mk_o(0,1,0,0,0,1,5'h1F,8'h5A,8'h00,1,1)};
        vecs[22] = '{mk_i(1,0,0,0,0,0,5'h00,5'h00,8'h00), quiet(1)};

        // Locked write burst on port 1 with port 0 waiting mid-burst
        bexp[0]  = quiet(0);
        bexp[1]  = mk_o(0,1,0,0,0,1,5'h00,8'h10,8'h00,1,1);
        bexp[2]  = mk_o(0,1,0,0,0,1,5'h01,8'h11,8'h00,1,1);
        bexp[3]  = mk_o(0,1,0,0,0,1,5'h02,8'h12,8'h00,1,1);
        bexp[4]  = mk_o(0,1,0,0,0,1,5'h03,8'h13,8'h00,1,1);
        bexp[5]  = quiet(1);
        bexp[6]  = mk_o(1,0,0,0,1,0,5'h0C,8'h00,8'h00,1,0);
        bexp[7]  = mk_o(0,0,1,0,0,0,5'h00,8'h00,8'hAC,1,0);
        bexp[8]  = quiet(0);
        bexp[9]  = mk_o(0,1,0,0,0,1,5'h04,8'h14,8'h00,1,1);
        bexp[10] = mk_o(0,1,0,0,0,1,5'h05,8'h15,8'h00,1,1);
        bexp[11] = quiet(1);

        lock0   = 1'b0;
        wdata0  = 8'h00;
        apply(mk_i(0,0,0,0,0,0,5'h00,5'h00,8'h00));
        preload = 1'b1;
        @(posedge clk);
        #1 preload = 1'b0;

        for (int k = 0; k < NV; k++) begin
            @(posedge clk);
            #1 apply(vecs[k].i);
            @(negedge clk);
            check($sformatf("vec%0d", k), vecs[k].o);
        end
        check_mem("single_write", 31, 8'h5A);

        // Reset asserted while the read is in RESP
        @(posedge clk);
        #1 begin req0 = 1'b1; we0 = 1'b0; addr0 = 5'h04; end
        @(negedge clk);
        check("mrr_idle", quiet(1));
        @(posedge clk);
        #1 req0 = 1'b0;
        @(negedge clk);
        check("mrr_issue", mk_o(1,0,0,0,1,0,5'h04,8'h00,8'h00,1,0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mrr_resp_in_reset", quiet(0));
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("mrr_after", quiet(0));

        // Six locked beats requested; cap forces a break after four
        @(posedge clk);
        #1 begin req1 = 1'b1; lock1 = 1'b1; we1 = 1'b1; addr1 = 5'h00; wdata1 = 8'h10; end
        beats = 0;
        for (int c = 0; c < NB; c++) begin
            @(negedge clk);
            check($sformatf("burst_c%0d", c), bexp[c]);
            if (c == 1) begin
                req0  = 1'b1;
                we0   = 1'b0;
                addr0 = 5'h0C;
            end
            if (gnt1) begin
                beats++;
                if (beats == 6) begin
                    req1  = 1'b0;
                    lock1 = 1'b0;
                end else begin
                    addr1  = 5'(beats);
                    wdata1 = 8'h10 + 8'(beats);
                end
            end
            if (gnt0) req0 = 1'b0;
        end
        for (int a = 0; a < 6; a++) begin
            check_mem($sformatf("burst_mem%0d", a), a, 8'h10 + 8'(a));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
